// File: rtl/pwmaudio_pkg.sv
// Shared definitions for the PWM audio path: sequencer state encoding and
// the mid-scale silence code used by both the sequencer and the datapath.
package pwmaudio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [7:0] PWMAUDIO_IDLE_VALUE = 8'h80;

endpackage

// File: rtl/pwmaudio_fifo.sv
// Small synchronous sample FIFO. Flush has priority over push/pop; push while
// full and pop while empty are ignored so the level stays within 0..DEPTH.
module pwmaudio_fifo #(
    parameter int DW      = 8,
    parameter int FIFO_AW = 2
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [DW-1:0]      wr_data,
    output logic [DW-1:0]      head,
    output logic [FIFO_AW:0]   level
);

    localparam int DEPTH = 2**FIFO_AW;
    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(DEPTH);

    logic [DW-1:0]      mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   level_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    // Qualify requests against the current occupancy.
    always_comb begin
        push_ok_s = push && (level_r != LVL_FULL);
        pop_ok_s  = pop && (level_r != {(FIFO_AW+1){1'b0}});
    end

    // Storage array; written only on an accepted push.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= wr_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers wrap naturally modulo DEPTH; level tracks push/pop balance.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            level_r  <= {(FIFO_AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            level_r  <= {(FIFO_AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_AW'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_AW'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + (FIFO_AW+1)'(1'b1);
                2'b01:   level_r <= level_r - (FIFO_AW+1)'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign level = level_r;

endmodule

// File: rtl/pwmaudio_sequencer.sv
// Sample-rate sequencer: buffers upstream samples and releases one every
// SAMPLE_DIV clocks, with priming, underrun concealment and flush-on-disable.
module pwmaudio_sequencer
    import pwmaudio_pkg::*;
#(
    parameter int             DW         = 8,
    parameter int             FIFO_AW    = 2,
    parameter int             SAMPLE_DIV = 1134,
    parameter int             FILL_LEVEL = 2,
    parameter logic [DW-1:0]  IDLE_VALUE = PWMAUDIO_IDLE_VALUE
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_enable,
    input  logic [DW-1:0]      i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [DW-1:0]      o_data,
    output logic               o_stb,
    output logic [FIFO_AW:0]   o_level,
    output logic               o_underrun,
    input  logic               i_clr_underrun
);

    localparam int DEPTH = 2**FIFO_AW;
    localparam int CW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] LVL_FILL = (FIFO_AW+1)'(FILL_LEVEL);

    state_t             state_r;
    state_t             state_nx_s;
    logic [CW-1:0]      cnt_r;
    logic               tick_s;
    logic               pop_s;
    logic               und_set_s;
    logic               ready_s;
    logic               push_s;
    logic [FIFO_AW:0]   level_s;
    logic [DW-1:0]      head_s;
    logic [DW-1:0]      data_r;
    logic               stb_r;
    logic               und_r;

    // Upstream handshake: room is judged on full only, never on a same-cycle pop.
    always_comb begin
        ready_s = i_enable && (level_s < LVL_FULL);
        push_s  = i_valid && ready_s;
    end

    pwmaudio_fifo #(
        .DW      (DW),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (!i_enable),
        .wr_data   (i_data),
        .head      (head_s),
        .level     (level_s)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state plus tick/pop/underrun decisions; disable overrides everything.
    always_comb begin
        state_nx_s = state_r;
        tick_s     = 1'b0;
        pop_s      = 1'b0;
        und_set_s  = 1'b0;
        if (!i_enable) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nx_s = ST_PRIME;
                end
                ST_PRIME: begin
                    if (level_s >= LVL_FILL) begin
                        state_nx_s = ST_RUN;
                    end else begin
                        state_nx_s = ST_PRIME;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == CNT_LAST) begin
                        tick_s = 1'b1;
                        if (level_s != {(FIFO_AW+1){1'b0}}) begin
                            pop_s = 1'b1;
                        end else begin
                            und_set_s  = 1'b1;
                            state_nx_s = ST_PRIME;
                        end
                    end else begin
                        tick_s = 1'b0;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // Tick counter: preloaded to the last value so the first tick follows RUN entry.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (!i_enable) begin
            cnt_r <= {CW{1'b0}};
        end else if ((state_r == ST_PRIME) && (state_nx_s == ST_RUN)) begin
            cnt_r <= CNT_LAST;
        end else if (state_r == ST_RUN) begin
            cnt_r <= tick_s ? {CW{1'b0}} : (cnt_r + CW'(1'b1));
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered datapath outputs and sticky underrun flag (set beats clear).
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_r <= IDLE_VALUE;
            stb_r  <= 1'b0;
            und_r  <= 1'b0;
        end else begin
            stb_r <= tick_s;
            if (!i_enable) begin
                data_r <= IDLE_VALUE;
            end else if (pop_s) begin
                data_r <= head_s;
            end else if (und_set_s) begin
                data_r <= IDLE_VALUE;
            end else begin
                data_r <= data_r;
            end
            if (und_set_s) begin
                und_r <= 1'b1;
            end else if (i_clr_underrun || !i_enable || (state_r == ST_IDLE)) begin
                und_r <= 1'b0;
            end else begin
                und_r <= und_r;
            end
        end
    end

    assign o_ready    = ready_s;
    assign o_data     = data_r;
    assign o_stb      = stb_r;
    assign o_level    = level_s;
    assign o_underrun = und_r;

endmodule

// File: tb/tb_pwmaudio_sequencer.sv
// Self-checking bench for pwmaudio_sequencer: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_pwmaudio_sequencer;

    localparam int DW         = 8;
    localparam int FIFO_AW    = 2;
    localparam int SAMPLE_DIV = 4;
    localparam int FILL_LEVEL = 2;
    localparam int DEPTH      = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       valid;
    logic       clr;
    logic [7:0] din;
    logic       o_ready;
    logic [7:0] o_data;
    logic       o_stb;
    logic [2:0] o_level;
    logic       o_und;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    // Reference model: plain sample queue plus a "clocks until next release" count.
    logic [7:0] m_q[$];
    int         m_mode;      // 0 silent, 1 waiting for fill, 2 playing
    int         m_wait;
    logic [7:0] m_data;
    bit         m_stb;
    bit         m_und;

    typedef struct {
        bit         en;
        bit         v;
        logic [7:0] d;
        bit         clr;
        bit         stb;
        logic [7:0] data;
        int         lvl;
        bit         und;
    } vec_t;

    vec_t tbl[14];

    always #5 clk = ~clk;

    pwmaudio_sequencer #(
        .DW         (DW),
        .FIFO_AW    (FIFO_AW),
        .SAMPLE_DIV (SAMPLE_DIV),
        .FILL_LEVEL (FILL_LEVEL),
        .IDLE_VALUE (8'h80)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_enable       (en),
        .i_data         (din),
        .i_valid        (valid),
        .o_ready        (o_ready),
        .o_data         (o_data),
        .o_stb          (o_stb),
        .o_level        (o_level),
        .o_underrun     (o_und),
        .i_clr_underrun (clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc_n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_mode = 0;
        m_wait = 0;
        m_data = 8'h80;
        m_stb  = 1'b0;
        m_und  = 1'b0;
    endtask

    task automatic model_edge(input bit e, input bit v, input logic [7:0] d, input bit c);
        bit rdy;
        bit psh;
        bit set;
        rdy = e && (m_q.size() < DEPTH);
        psh = v && rdy;
        set = 1'b0;
        if (!e) begin
            model_reset();
        end else begin
            m_stb = 1'b0;
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (m_q.size() >= FILL_LEVEL) begin
                    m_mode = 2;
                    m_wait = 1;
                end
            end else begin
                if (m_wait == 1) begin
                    m_wait = SAMPLE_DIV;
                    m_stb  = 1'b1;
                    if (m_q.size() > 0) begin
                        m_data = m_q.pop_front();
                    end else begin
                        m_data = 8'h80;
                        set    = 1'b1;
                        m_mode = 1;
                    end
                end else begin
                    m_wait--;
                end
            end
            if (set) m_und = 1'b1;
            else if (c) m_und = 1'b0;
            if (psh) m_q.push_back(d);
        end
    endtask

    // One clock: drive inputs, check ready, clock, check outputs against the model.
    task automatic cyc(input bit e, input bit v, input logic [7:0] d, input bit c);
        en    = e;
        valid = v;
        din   = d;
        clr   = c;
        #1;
        chk("ready", 32'(o_ready), 32'(e && (m_q.size() < DEPTH)));
        @(posedge clk);
        model_edge(e, v, d, c);
        cyc_n++;
        #1;
        chk("data",     32'(o_data),  32'(m_data));
        chk("stb",      32'(o_stb),   32'(m_stb));
        chk("level",    32'(o_level), 32'(m_q.size()));
        chk("underrun", 32'(o_und),   32'(m_und));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sent[$];
        logic [7:0] got[$];
        int         stb_at[$];
        logic [7:0] d;
        bit         v;
        int         guard;

        // Priming, two strobes, underrun and flag clear from a fresh reset.
        tbl[0]  = '{1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 8'h80, 1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 8'h80, 2, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h80, 2, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h20, 0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h20, 0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h20, 0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h20, 0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h80, 0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h80, 0, 1'b0};

        rst_n = 1'b0;
        en    = 1'b0;
        valid = 1'b0;
        clr   = 1'b0;
        din   = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_data",  32'(o_data),  32'h80);
        chk("rst_stb",   32'(o_stb),   32'h0);
        chk("rst_level", 32'(o_level), 32'h0);
        chk("rst_und",   32'(o_und),   32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].clr);
            chk("tbl_stb",   32'(o_stb),   32'(tbl[i].stb));
            chk("tbl_data",  32'(o_data),  32'(tbl[i].data));
            chk("tbl_level", 32'(o_level), 32'(tbl[i].lvl));
            chk("tbl_und",   32'(o_und),   32'(tbl[i].und));
        end

        // Full: back-to-back pushes fill the FIFO; further pushes wait for a pop.
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 8'h31 + 8'(i), 1'b0);
        end
        en    = 1'b1;
        valid = 1'b1;
        #1;
        chk("full_level", 32'(o_level), 32'd4);
        chk("full_ready", 32'(o_ready), 32'd0);
        cyc(1'b1, 1'b1, 8'h36, 1'b0);
        chk("full_hold", 32'(o_level), 32'd4);
        cyc(1'b1, 1'b1, 8'h36, 1'b0);
        cyc(1'b1, 1'b1, 8'h36, 1'b0);
        chk("full_popped", 32'(o_level), 32'd3);
        cyc(1'b1, 1'b1, 8'h36, 1'b0);
        chk("full_refill", 32'(o_level), 32'd4);

        // Disable mid-run with three samples queued.
        guard = 0;
        while ((m_q.size() != 3) && (guard < 20)) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b0);
            guard++;
        end
        chk("dis_queued", 32'(o_level), 32'd3);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("dis_data",  32'(o_data),  32'h80);
        chk("dis_level", 32'(o_level), 32'd0);
        chk("dis_stb",   32'(o_stb),   32'd0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0);
            chk("dis_nostb", 32'(o_stb), 32'd0);
        end
        cyc(1'b1, 1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b0);
            chk("reprime_nostb", 32'(o_stb), 32'd0);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0);

        // Steady stream: one sample every SAMPLE_DIV clocks after priming.
        for (int c = 0; c < 40; c++) begin
            d = 8'($urandom);
            v = (c < 2) || (((c - 2) % 4) == 0);
            cyc(1'b1, v, d, 1'b0);
            if (v) sent.push_back(d);
            if (o_stb) begin
                got.push_back(o_data);
                stb_at.push_back(c);
            end
        end
        chk("steady_count", 32'(got.size()), 32'd10);
        for (int i = 0; i < got.size(); i++) begin
            chk("steady_order", 32'(got[i]), 32'(sent[i]));
            if (i > 0) chk("steady_period", 32'(stb_at[i] - stb_at[i-1]), 32'd4);
        end
        chk("steady_und", 32'(o_und), 32'd0);

        // Asynchronous reset in the middle of playback, away from any edge.
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_data",  32'(o_data),  32'h80);
        chk("arst_stb",   32'(o_stb),   32'h0);
        chk("arst_level", 32'(o_level), 32'h0);
        chk("arst_und",   32'(o_und),   32'h0);
        en = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 16) != 0, ($urandom % 3) != 0, 8'($urandom), ($urandom % 8) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
